// File: rtl/frame_buffer_server_if.sv
// Camera-write and hunt-read signal bundle for frame_buffer_server.
// The master drives the camera stream and read addresses; the slave (frame store) returns pixels and status.
interface frame_buffer_server_if #(
    parameter int PIXEL_W = 9
);
    logic [PIXEL_W-1:0] cam_pixel;
    logic               cam_valid;
    logic               cam_sof;
    logic               mem_request;
    logic               hunt_done;
    logic [9:0]         mem_hcount;
    logic [9:0]         mem_vcount;
    logic [PIXEL_W-1:0] mem_pixel_data;
    logic               frame_ready;
    logic [7:0]         dropped_frames;

    modport master (
        output cam_pixel, cam_valid, cam_sof, mem_request, hunt_done, mem_hcount, mem_vcount,
        input  mem_pixel_data, frame_ready, dropped_frames
    );

    modport slave (
        input  cam_pixel, cam_valid, cam_sof, mem_request, hunt_done, mem_hcount, mem_vcount,
        output mem_pixel_data, frame_ready, dropped_frames
    );
endinterface

// File: rtl/frame_buffer_server.sv
// Double-buffered frame store: raster writer fills one bank, random-access reads (2-cycle latency) hit the other.
// No backpressure; banks swap only at frame starts. FRAME_BUFFER_DROP_COUNT_EN enables the dropped-frame counter.
module frame_buffer_server #(
    parameter int WIDTH   = 240,
    parameter int HEIGHT  = 240,
    parameter int PIXEL_W = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    frame_buffer_server_if.slave  bus
);
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_COMPLETE
    } wr_state_t;

    logic [PIXEL_W-1:0] mem [2][DEPTH];

    wr_state_t          state_q, state_d;
    logic               wr_bank_q, wr_bank_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic               pending_q, pending_d;
    logic               locked_q, locked_d;
    logic               frame_ready_q, frame_ready_d;

    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic               rd_in_range_q, rd_in_range_d;
    logic               rd_sel_q, rd_sel_d;
    logic [PIXEL_W-1:0] pix_q;

    logic               sof_evt;
    logic               lock_for_swap;
    logic               rd_bank;
    logic               wr_en;
    logic               wr_sel;
    logic [AW-1:0]      wr_waddr;

    assign sof_evt = bus.cam_valid & bus.cam_sof;
    // A release in the same cycle as a frame start counts before the swap decision; a new request does not.
    assign lock_for_swap = locked_q & ~bus.hunt_done;
    assign rd_bank = ~wr_bank_q;

    always_comb begin
        state_d       = state_q;
        wr_bank_d     = wr_bank_q;
        wr_addr_d     = wr_addr_q;
        pending_d     = pending_q;
        frame_ready_d = frame_ready_q;
        wr_en         = 1'b0;
        wr_waddr      = wr_addr_q;

        if (bus.mem_request) begin
            locked_d = 1'b1;
        end else if (bus.hunt_done) begin
            locked_d = 1'b0;
        end else begin
            locked_d = locked_q;
        end

        if (sof_evt) begin
            wr_en     = 1'b1;
            wr_waddr  = '0;
            wr_addr_d = AW'(1);
            state_d   = ST_FILL;
            if (pending_q) begin
                pending_d = 1'b0;
                if (!lock_for_swap) begin
                    wr_bank_d     = ~wr_bank_q;
                    frame_ready_d = 1'b1;
                end
            end
        end else if (bus.cam_valid && state_q == ST_FILL) begin
            wr_en = 1'b1;
            if (wr_addr_q == LAST_ADDR) begin
                pending_d = 1'b1;
                state_d   = ST_COMPLETE;
            end else begin
                wr_addr_d = wr_addr_q + AW'(1);
            end
        end

        // The frame-start pixel lands in the bank that is the write bank after any swap.
        wr_sel = wr_bank_d;
    end

    always_comb begin
        rd_in_range_d = (bus.mem_hcount < 10'(WIDTH)) && (bus.mem_vcount < 10'(HEIGHT));
        rd_addr_d     = AW'(17'(bus.mem_vcount) * 17'(WIDTH) + 17'(bus.mem_hcount));
        rd_sel_d      = rd_bank;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_bank_q     <= 1'b0;
            wr_addr_q     <= '0;
            pending_q     <= 1'b0;
            locked_q      <= 1'b0;
            frame_ready_q <= 1'b0;
            rd_addr_q     <= '0;
            rd_in_range_q <= 1'b0;
            rd_sel_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            wr_addr_q     <= wr_addr_d;
            pending_q     <= pending_d;
            locked_q      <= locked_d;
            frame_ready_q <= frame_ready_d;
            rd_addr_q     <= rd_addr_d;
            rd_in_range_q <= rd_in_range_d;
            rd_sel_q      <= rd_sel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_sel][wr_waddr] <= bus.cam_pixel;
        end
    end

    // Registered BRAM read; the synchronous clear doubles as the out-of-range zero.
    always_ff @(posedge clk) begin
        if (reset || !rd_in_range_q) begin
            pix_q <= '0;
        end else begin
            pix_q <= mem[rd_sel_q][rd_addr_q];
        end
    end

    assign bus.mem_pixel_data = pix_q;
    assign bus.frame_ready    = frame_ready_q;

`ifdef FRAME_BUFFER_DROP_COUNT_EN
    logic       drop_evt;
    logic [7:0] dropped_q, dropped_d;

    assign drop_evt = sof_evt & pending_q & lock_for_swap;

    always_comb begin
        dropped_d = dropped_q;
        if (drop_evt && dropped_q != 8'hFF) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_q <= '0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    assign bus.dropped_frames = dropped_q;
`else
    assign bus.dropped_frames = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_server.sv
// Scoreboard bench for frame_buffer_server on a 240x2 frame; reads are checked two cycles after issue.
module tb_frame_buffer_server;
    localparam int W = 240;
    localparam int H = 2;
    localparam int N = W * H;
`ifdef FRAME_BUFFER_DROP_COUNT_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    frame_buffer_server_if #(.PIXEL_W(9)) bus();

    frame_buffer_server #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_v;
    logic rd_issue = 1'b0;
    logic rd_p1 = 1'b0;
    logic rd_p2 = 1'b0;

    always @(posedge clk) begin
        rd_p1 <= rd_issue;
        rd_p2 <= rd_p1;
    end

    // Monitor: a read issued two edges ago is due on mem_pixel_data now.
    always @(negedge clk) begin
        if (rd_p2) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: got %0d with empty scoreboard", bus.mem_pixel_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.mem_pixel_data !== exp_v) begin
                    errors++;
                    $display("FAIL read_data: got %0d expected %0d", bus.mem_pixel_data, exp_v);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [8:0] val(input int a, input int off);
        return 9'((a + off) % 512);
    endfunction

    task automatic cyc(input logic v, input logic s, input logic [8:0] px, input logic req,
                       input logic done, input int h, input int vv, input logic rd);
        @(posedge clk);
        #1;
        bus.cam_valid   = v;
        bus.cam_sof     = s;
        bus.cam_pixel   = px;
        bus.mem_request = req;
        bus.hunt_done   = done;
        bus.mem_hcount  = 10'(h);
        bus.mem_vcount  = 10'(vv);
        rd_issue        = rd;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic pix(input logic s, input int a, input int off);
        cyc(1'b1, s, val(a, off), 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic frame_rest(input int off, input int from, input int upto);
        for (int a = from; a < upto; a++) pix(1'b0, a, off);
    endtask

    task automatic rd(input int h, input int v, input logic [8:0] e);
        exp_q.push_back(e);
        cyc(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, h, v, 1'b1);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    initial begin
        bus.cam_valid   = 1'b0;
        bus.cam_sof     = 1'b0;
        bus.cam_pixel   = '0;
        bus.mem_request = 1'b0;
        bus.hunt_done   = 1'b0;
        bus.mem_hcount  = '0;
        bus.mem_vcount  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_pixel", int'(bus.mem_pixel_data), 0);
        chk("reset_frame_ready", int'(bus.frame_ready), 0);
        chk("reset_dropped", int'(bus.dropped_frames), 0);

        // Frame 0 (value = addr), then frame A's start swaps it in.
        pix(1'b1, 0, 0);
        frame_rest(0, 1, N);
        idle(2);
        chk("ready_before_boundary", int'(bus.frame_ready), 0);
        pix(1'b1, 0, 100);
        idle(1);
        chk("ready_after_swap", int'(bus.frame_ready), 1);
        chk("dropped_after_swap", int'(bus.dropped_frames), 0);
        rd(5, 1, 9'd245);
        rd(1, 0, 9'd1);
        rd(239, 1, 9'd479);
        rd(239, 0, 9'd239);
        rd(240, 0, 9'd0);
        rd(0, 300, 9'd0);
        rd(0, 2, 9'd0);
        rd(1023, 1023, 9'd0);
        idle(3);

        // Frame B start swaps in A; reader then locks A.
        frame_rest(100, 1, N);
        pix(1'b1, 0, 200);
        cyc(1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 0, 0, 1'b0);
        rd(5, 1, val(245, 100));
        frame_rest(200, 1, N);

        // Frame C start while locked: B is dropped, reads stay on A.
        pix(1'b1, 0, 300);
        idle(1);
        chk("dropped_after_lock", int'(bus.dropped_frames), DROP_EN);
        chk("ready_held", int'(bus.frame_ready), 1);
        rd(5, 1, val(245, 100));
        rd(239, 1, val(479, 100));
        frame_rest(300, 1, 100);
        cyc(1'b0, 1'b0, 9'd0, 1'b0, 1'b1, 0, 0, 1'b0);
        frame_rest(300, 100, N);

        // Frame D start after release: C swapped in.
        pix(1'b1, 0, 400);
        rd(5, 1, val(245, 300));
        rd(239, 1, val(479, 300));

        // Short frame D, then frame E start: no swap, no drop.
        frame_rest(400, 1, 100);
        pix(1'b1, 0, 50);
        idle(1);
        chk("ready_after_short", int'(bus.frame_ready), 1);
        chk("dropped_after_short", int'(bus.dropped_frames), DROP_EN);
        rd(5, 1, val(245, 300));

        // Complete E, extra pixels must be ignored, then sof F together with mem_request.
        frame_rest(50, 1, N);
        repeat (3) cyc(1'b1, 1'b0, 9'h1FF, 1'b0, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 1'b1, val(0, 150), 1'b1, 1'b0, 0, 0, 1'b0);
        rd(5, 1, val(245, 50));
        rd(239, 1, val(479, 50));

        // Lock taken on the swap cycle holds: frame G start drops F.
        frame_rest(150, 1, N);
        pix(1'b1, 0, 250);
        idle(1);
        chk("dropped_second", int'(bus.dropped_frames), 2 * DROP_EN);
        rd(5, 1, val(245, 50));

        // Frame H start together with hunt_done: release first, G swapped in.
        frame_rest(250, 1, N);
        cyc(1'b1, 1'b1, val(0, 350), 1'b0, 1'b1, 0, 0, 1'b0);
        rd(5, 1, val(245, 250));
        rd(239, 1, val(479, 250));
        idle(3);

        // Reset in the middle of filling H.
        frame_rest(350, 1, 50);
        chk("pixel_nonzero_before_reset", int'(bus.mem_pixel_data != 9'd0), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        bus.cam_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("midreset_pixel", int'(bus.mem_pixel_data), 0);
        chk("midreset_frame_ready", int'(bus.frame_ready), 0);
        chk("midreset_dropped", int'(bus.dropped_frames), 0);

        idle(4);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
